pdm_decimator: RTL and testbench

- Sits directly downstream of the PDM microphone deserializer and consumes its 16-bit PDM words and one-cycle word-ready strobe.
- Converts each word to a ones-count and boxcar-accumulates 2^DECIM_LOG2 words into one PCM sample.
- Centres, gains and saturates that sum into signed 16-bit PCM, then buffers it in a small FIFO with a valid/ready output handshake for the downstream audio consumer.

---
 rtl/pdm_decimator.sv | 126 ++++++++++++
 tb/tb_pdm_decimator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: popcount each 16-bit PDM word, boxcar-sum 2^DECIM_LOG2 words,
// centre/gain/saturate to signed 16-bit PCM and queue it in a first-word-fall-through FIFO.
module pdm_decimator #(
  parameter int DECIM_LOG2 = 4,
  parameter int GAIN_SHIFT = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          word_valid_i,
  input  logic [15:0]                   word_i,
  output logic [15:0]                   sample_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  input  logic                          clear_overflow_i
);

  localparam int DECIM = 1 << DECIM_LOG2;
  localparam int SUM_W = 5 + DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic signed [31:0] MIDSCALE = 32'(8 * DECIM);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DECIM - 1);

  function automatic logic [4:0] popcount16(input logic [15:0] w);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(w[i]);
    return n;
  endfunction

  // Centre on mid-scale, apply gain, clamp to the signed 16-bit range.
  function automatic logic signed [15:0] form_sample(input logic [SUM_W-1:0] s);
    logic signed [31:0] c;
    logic signed [31:0] v;
    c = $signed(32'(s)) - MIDSCALE;
    v = c <<< GAIN_SHIFT;
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return $signed(v[15:0]);
  endfunction

  logic                    vld_p0;
  logic [4:0]              pc_p0;
  logic [SUM_W-1:0]        acc_p1;
  logic [CNT_W-1:0]        word_cnt_p1;
  logic [SUM_W-1:0]        sum_p1;
  logic signed [15:0]      pcm_p1;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    wr_en;
  logic                    drop;
  logic [15:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  // Stage 1: popcount
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p0 <= 1'b0;
      pc_p0  <= '0;
    end else begin
      vld_p0 <= word_valid_i && enable_i;
      if (word_valid_i && enable_i) pc_p0 <= popcount16(word_i);
    end
  end

  // Stage 2: accumulate and form sample
  assign sum_p1 = acc_p1 + SUM_W'(pc_p0);
  assign pcm_p1 = form_sample(sum_p1);
  assign push   = vld_p0 && enable_i && (word_cnt_p1 == LAST_CNT);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      acc_p1      <= '0;
      word_cnt_p1 <= '0;
    end else if (!enable_i) begin
      acc_p1      <= '0;
      word_cnt_p1 <= '0;
    end else if (vld_p0) begin
      if (word_cnt_p1 == LAST_CNT) begin
        acc_p1      <= '0;
        word_cnt_p1 <= '0;
      end else begin
        acc_p1      <= sum_p1;
        word_cnt_p1 <= word_cnt_p1 + CNT_W'(1);
      end
    end
  end

  // Output FIFO; a pop frees the slot for a same-edge push even when full.
  assign sample_valid_o = (fifo_count_o != '0);
  assign full           = (fifo_count_o == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign pop            = sample_valid_o && sample_ready_i;
  assign wr_en          = push && (!full || pop);
  assign drop           = push && full && !pop;
  assign sample_o       = sample_valid_o ? mem[rd_ptr] : 16'h0000;

  always_ff @(posedge clock_i) begin
    if (wr_en) mem[wr_ptr] <= pcm_p1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count_o <= fifo_count_o + 1'b1;
        2'b01:   fifo_count_o <= fifo_count_o - 1'b1;
        default: fifo_count_o <= fifo_count_o;
      endcase
      if (drop)                  overflow_o <= 1'b1;
      else if (clear_overflow_i) overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator at DECIM_LOG2=4, GAIN_SHIFT=8, FIFO_DEPTH=8.
module tb_pdm_decimator;

  localparam int DECIM = 16;
  localparam int DEPTH = 8;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        word_valid_i = 1'b0;
  logic [15:0] word_i = 16'h0000;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i = 1'b0;
  logic [3:0]  fifo_count_o;
  logic        overflow_o;
  logic        clear_overflow_i = 1'b0;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] sb [$];

  pdm_decimator #(.DECIM_LOG2(4), .GAIN_SHIFT(8), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .word_valid_i(word_valid_i), .word_i(word_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
    .fifo_count_o(fifo_count_o), .overflow_o(overflow_o), .clear_overflow_i(clear_overflow_i)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [15:0] model_pcm(input int sum);
    int c, v;
    c = sum - 8 * DECIM;
    v = c * 256;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic send_word(input logic [15:0] w);
    word_valid_i = 1'b1;
    word_i = w;
    @(posedge clock_i); #1;
    word_valid_i = 1'b0;
  endtask

  task automatic send_group(input logic [15:0] rest, input logic [15:0] last, output logic [15:0] exp);
    int sum;
    sum = 0;
    for (int i = 0; i < DECIM - 1; i++) begin
      send_word(rest);
      sum += $countones(rest);
    end
    send_word(last);
    sum += $countones(last);
    exp = model_pcm(sum);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock_i);
    #1;
    checks++; if (sample_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", sample_valid_o); else passes++;
    checks++; if (fifo_count_o !== 4'd0) $display("FAIL rst_count: got %0d want 0", fifo_count_o); else passes++;
    checks++; if (overflow_o !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow_o); else passes++;
    checks++; if (sample_o !== 16'h0000) $display("FAIL rst_sample: got %h want 0000", sample_o); else passes++;
    @(negedge clock_i); reset_i = 1'b0;
    @(posedge clock_i); #1; enable_i = 1'b1;
  endtask

  task automatic test_full_scale();
    logic [15:0] e;
    int n;
    send_group(16'hFFFF, 16'hFFFF, e);
    sb.push_back(e);
    checks++; if (sample_valid_o !== 1'b0) $display("FAIL fs_early_valid: got %b want 0", sample_valid_o); else passes++;
    @(posedge clock_i); #1;
    checks++; if (sample_valid_o !== 1'b1) $display("FAIL fs_valid: got %b want 1", sample_valid_o); else passes++;
    checks++; if (fifo_count_o !== 4'd1) $display("FAIL fs_count: got %0d want 1", fifo_count_o); else passes++;
    sample_ready_i = 1'b1;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock_i);
      e = sb.pop_front();
      checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== e) $display("FAIL fs_drain[%0d]: got valid=%b sample=%h want valid=1 sample=%h", k, sample_valid_o, sample_o, e);
      else passes++;
    end
    @(posedge clock_i); #1; sample_ready_i = 1'b0;
  endtask

  task automatic test_patterns();
    logic [15:0] e;
    int n;
    send_group(16'h0000, 16'h0000, e); sb.push_back(e);
    send_group(16'hAAAA, 16'hAAAA, e); sb.push_back(e);
    send_group(16'h0000, 16'h00FF, e); sb.push_back(e);
    @(posedge clock_i); #1;
    checks++; if (fifo_count_o !== 4'd3) $display("FAIL pat_count: got %0d want 3", fifo_count_o); else passes++;
    sample_ready_i = 1'b1;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock_i);
      e = sb.pop_front();
      checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== e) $display("FAIL pat_drain[%0d]: got valid=%b sample=%h want valid=1 sample=%h", k, sample_valid_o, sample_o, e);
      else passes++;
    end
    @(posedge clock_i); #1; sample_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    int n;
    for (int g = 0; g < DEPTH + 1; g++) begin
      send_group(16'hAAAA, 16'((1 << g) - 1), e);
      if (sb.size() < DEPTH) sb.push_back(e);
    end
    @(posedge clock_i); #1;
    checks++; if (fifo_count_o !== 4'd8) $display("FAIL ovf_count: got %0d want 8", fifo_count_o); else passes++;
    checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_o); else passes++;
    sample_ready_i = 1'b1;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock_i);
      e = sb.pop_front();
      checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== e) $display("FAIL ovf_drain[%0d]: got valid=%b sample=%h want valid=1 sample=%h", k, sample_valid_o, sample_o, e);
      else passes++;
    end
    @(posedge clock_i); #1; sample_ready_i = 1'b0;
    checks++; if (sample_valid_o !== 1'b0) $display("FAIL ovf_empty: got %b want 0", sample_valid_o); else passes++;
    checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_o); else passes++;
    clear_overflow_i = 1'b1;
    @(posedge clock_i); #1; clear_overflow_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow_o); else passes++;
  endtask

  task automatic test_push_pop_full();
    logic [15:0] e;
    int n;
    for (int g = 0; g < DEPTH; g++) begin
      send_group(16'hAAAA, 16'((1 << (g + 2)) - 1), e);
      sb.push_back(e);
    end
    @(posedge clock_i); #1;
    checks++; if (fifo_count_o !== 4'd8) $display("FAIL ppf_fill: got %0d want 8", fifo_count_o); else passes++;
    send_group(16'h0000, 16'h00FF, e);
    sample_ready_i = 1'b1;
    checks++;
    if (sample_o !== sb[0]) $display("FAIL ppf_head: got %h want %h", sample_o, sb[0]); else passes++;
    void'(sb.pop_front());
    sb.push_back(e);
    @(posedge clock_i); #1; sample_ready_i = 1'b0;
    checks++; if (fifo_count_o !== 4'd8) $display("FAIL ppf_count: got %0d want 8", fifo_count_o); else passes++;
    checks++; if (overflow_o !== 1'b0) $display("FAIL ppf_ovf: got %b want 0", overflow_o); else passes++;
    sample_ready_i = 1'b1;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock_i);
      e = sb.pop_front();
      checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== e) $display("FAIL ppf_drain[%0d]: got valid=%b sample=%h want valid=1 sample=%h", k, sample_valid_o, sample_o, e);
      else passes++;
    end
    @(posedge clock_i); #1; sample_ready_i = 1'b0;
  endtask

  task automatic test_enable_flush();
    logic [15:0] e;
    int n;
    send_group(16'hAAAA, 16'h0001, e); sb.push_back(e);
    send_group(16'hFFFF, 16'hFFFF, e); sb.push_back(e);
    for (int i = 0; i < 5; i++) send_word(16'hFFFF);
    enable_i = 1'b0;
    word_valid_i = 1'b1;
    word_i = 16'hFFFF;
    @(posedge clock_i); #1;
    word_valid_i = 1'b0;
    enable_i = 1'b1;
    send_group(16'hAAAA, 16'hAAAA, e); sb.push_back(e);
    @(posedge clock_i); #1;
    checks++; if (fifo_count_o !== 4'd3) $display("FAIL en_count: got %0d want 3", fifo_count_o); else passes++;
    sample_ready_i = 1'b1;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock_i);
      e = sb.pop_front();
      checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== e) $display("FAIL en_drain[%0d]: got valid=%b sample=%h want valid=1 sample=%h", k, sample_valid_o, sample_o, e);
      else passes++;
    end
    @(posedge clock_i); #1; sample_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    int n;
    for (int g = 0; g < 3; g++) send_group(16'hAAAA, 16'((1 << g) - 1), e);
    for (int i = 0; i < 7; i++) send_word(16'hFFFF);
    @(posedge clock_i); #3;
    checks++; if (fifo_count_o !== 4'd3) $display("FAIL ar_pre_count: got %0d want 3", fifo_count_o); else passes++;
    reset_i = 1'b1;
    #1;
    checks++; if (sample_valid_o !== 1'b0) $display("FAIL ar_valid: got %b want 0", sample_valid_o); else passes++;
    checks++; if (fifo_count_o !== 4'd0) $display("FAIL ar_count: got %0d want 0", fifo_count_o); else passes++;
    checks++; if (overflow_o !== 1'b0) $display("FAIL ar_ovf: got %b want 0", overflow_o); else passes++;
    sb.delete();
    @(negedge clock_i); reset_i = 1'b0;
    @(posedge clock_i); #1;
    send_group(16'h0000, 16'h00FF, e); sb.push_back(e);
    @(posedge clock_i); #1;
    checks++; if (fifo_count_o !== 4'd1) $display("FAIL ar_post_count: got %0d want 1", fifo_count_o); else passes++;
    sample_ready_i = 1'b1;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock_i);
      e = sb.pop_front();
      checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== e) $display("FAIL ar_drain[%0d]: got valid=%b sample=%h want valid=1 sample=%h", k, sample_valid_o, sample_o, e);
      else passes++;
    end
    @(posedge clock_i); #1; sample_ready_i = 1'b0;
    checks++; if (sample_valid_o !== 1'b0) $display("FAIL ar_empty: got %b want 0", sample_valid_o); else passes++;
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_patterns();
    test_overflow();
    test_push_pop_full();
    test_enable_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
